core_control_unit: RTL and testbench
====================================

CORE_CONTROL_UNIT -- requirements
Module: core_control_unit

Interface
REQ-001 Parameter WIDTH, default 8, data/address width of AC, BusOut, PC and instruction bytes.
REQ-002 Parameter CORE_ID_W, default 8, width of coreID.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins execution from address 0 when in IDLE.
REQ-006 core_id_in  input  CORE_ID_W  static core identity, registered and driven out as coreID.
REQ-007 imem_addr  output  WIDTH  instruction memory address (synchronous ROM, data valid one cycle after address).
REQ-008 imem_data  input  WIDTH  instruction memory read data.
REQ-009 BusOut  input  WIDTH  bus operand, qualified by bus_valid.
REQ-010 bus_valid  input  1  BusOut holds valid data this cycle.
REQ-011 bus_req  output  1  block is waiting for a bus operand.
REQ-012 result_ac  input  WIDTH  combinational ALU result for current AC/BusOut/ALU_OP.
REQ-013 AC  output  WIDTH  accumulator register, feeds the ALU.
REQ-014 ALU_OP  output  4  ALU operation select, valid in EXEC only, 4'b0000 elsewhere.
REQ-015 coreID  output  CORE_ID_W  registered core_id_in.
REQ-016 done  output  1  high from HALT execution until next start.

Function
REQ-017 Instruction byte: [7:4] class, [3:0] ALU_OP field; classes NOP 0000, LDB 0001 (AC<=BusOut), ALU 0010 (AC<=result_ac), LDI 0011 (AC<=operand byte), JMP 0100, JZ 0101, HALT 1111; other classes execute as NOP.
REQ-018 LDI, JMP, JZ are two-byte (opcode then operand); all others one-byte.
REQ-019 States IDLE, FETCH, DECODE, OPERAND, EXEC; IDLE->FETCH on start (PC<=0, done<=0).
REQ-020 FETCH: imem_addr=PC; next state DECODE.
REQ-021 DECODE: IR<=imem_data, PC<=PC+1; two-byte -> OPERAND (imem_addr=PC+1), else -> EXEC.
REQ-022 OPERAND: OPR<=imem_data, PC<=PC+1; -> EXEC.
REQ-023 EXEC: one-byte latency 3 cycles, two-byte latency 4 cycles, excluding bus wait; -> FETCH except HALT -> IDLE with done<=1.
REQ-024 ALU in EXEC: ALU_OP=IR[3:0], BusOut sampled; bus_req=1; AC<=result_ac on the first cycle bus_valid=1, stall in EXEC otherwise.
REQ-025 LDB in EXEC: bus_req=1; AC<=BusOut when bus_valid=1, stall otherwise.
REQ-026 JMP: PC<=OPR; JZ: PC<=OPR if AC==0, else PC unchanged.
REQ-027 PC arithmetic modulo 2^WIDTH; PC=2^WIDTH-1 increments to 0.
REQ-028 start ignored outside IDLE; start in IDLE with done=1 clears done and restarts.
REQ-029 AC holds its value through IDLE/HALT; readable after done.

Reset
REQ-030 Reset asserted: state=IDLE, PC=0, IR=0, OPR=0, AC=0, coreID=0, ALU_OP=0, bus_req=0, done=0, imem_addr=0, immediately and regardless of state.
REQ-031 Reset mid-stall in EXEC abandons the instruction; no AC update.

Structure
REQ-032 Shared package holds class encodings, ALU_OP encodings and state encoding; ALU and this block both import it.
REQ-033 One sub-module, ccu_decoder: combinational IR -> {is_two_byte, needs_bus, writes_ac, is_jump, is_halt}.

Verification
REQ-034 Reset mid-program: AC=8'h15, assert Reset -> AC=0, state IDLE, done=0 same cycle.
REQ-035 ROM {LDI 8'h15, HALT}, start -> AC=8'h15 after 4 cycles, done=1 after further 3 cycles.
REQ-036 ROM {LDB, ALU ADD, HALT}, bus_valid held low 5 cycles, BusOut=8'hAA -> ALU_OP=0001 held, bus_req=1, AC unchanged until bus_valid, then AC=result_ac.
REQ-037 ROM {LDI 0, JZ 8'h10}, HALT at 8'h10 -> PC=8'h10, done=1; same with LDI 1 -> falls through to next address.
REQ-038 JMP 8'hFE, 1-byte NOP at 8'hFF -> PC wraps 8'hFF->8'h00, fetch continues at 0.
REQ-039 start pulsed during EXEC -> ignored, no restart; core_id_in=8'h03 -> coreID=8'h03 one cycle later.

Source files
------------

// File: rtl/core_control_unit_pkg.sv
// core_control_unit_pkg: instruction class, ALU op, FSM state and decode encodings
package core_control_unit_pkg;
  typedef enum logic [3:0] {
    CLS_NOP  = 4'h0,
    CLS_LDB  = 4'h1,
    CLS_ALU  = 4'h2,
    CLS_LDI  = 4'h3,
    CLS_JMP  = 4'h4,
    CLS_JZ   = 4'h5,
    CLS_HALT = 4'hF
  } cls_e;
  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_NOT  = 4'h6;
  localparam logic [3:0] ALU_PASS = 4'h7;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC
  } state_e;
  typedef struct packed {
    logic is_two_byte;
    logic needs_bus;
    logic writes_ac;
    logic is_jump;
    logic is_halt;
  } dec_t;
endpackage

// File: rtl/ccu_decoder.sv
// ccu_decoder: combinational opcode byte -> instruction attributes
module ccu_decoder
  import core_control_unit_pkg::*;
(
  input  logic [7:0] opc,
  output dec_t       dec
);
  logic [3:0] cls;
  assign cls             = opc[7:4];
  assign dec.is_two_byte = cls == CLS_LDI || cls == CLS_JMP || cls == CLS_JZ;
  assign dec.needs_bus   = cls == CLS_LDB || cls == CLS_ALU;
  assign dec.writes_ac   = cls == CLS_LDB || cls == CLS_ALU || cls == CLS_LDI;
  assign dec.is_jump     = cls == CLS_JMP || cls == CLS_JZ;
  assign dec.is_halt     = cls == CLS_HALT;
endmodule

// File: rtl/core_control_unit.sv
// core_control_unit: fetch/decode/execute sequencer owning PC, IR, operand and accumulator
module core_control_unit
  import core_control_unit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CORE_ID_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [CORE_ID_W-1:0] core_id_in,
  output logic [WIDTH-1:0]     imem_addr,
  input  logic [WIDTH-1:0]     imem_data,
  input  logic [WIDTH-1:0]     BusOut,
  input  logic                 bus_valid,
  output logic                 bus_req,
  input  logic [WIDTH-1:0]     result_ac,
  output logic [WIDTH-1:0]     AC,
  output logic [3:0]           ALU_OP,
  output logic [CORE_ID_W-1:0] coreID,
  output logic                 done
);
  state_e           state, state_nx;
  logic [WIDTH-1:0] pc, ir, opr, dec_in;
  logic [3:0]       cls;
  logic             stall;
  dec_t             dec;
  // in DECODE the opcode is still on the ROM bus, IR only holds it afterwards
  assign dec_in = state == S_DECODE ? imem_data : ir;
  assign cls    = ir[7:4];
  ccu_decoder u_dec (.opc(dec_in[7:0]), .dec(dec));
  always_comb begin
    stall     = dec.needs_bus && !bus_valid;
    imem_addr = state == S_DECODE && dec.is_two_byte ? pc + WIDTH'(1) : pc;
    bus_req   = state == S_EXEC && dec.needs_bus;
    ALU_OP    = state == S_EXEC && cls == CLS_ALU ? ir[3:0] : ALU_NONE;
    state_nx  = state == S_IDLE    ? (start ? S_FETCH : S_IDLE) :
                state == S_FETCH   ? S_DECODE :
                state == S_DECODE  ? (dec.is_two_byte ? S_OPERAND : S_EXEC) :
                state == S_OPERAND ? S_EXEC :
                stall              ? S_EXEC :
                dec.is_halt        ? S_IDLE : S_FETCH;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      opr    <= '0;
      AC     <= '0;
      coreID <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      coreID <= core_id_in;
      if (state == S_IDLE && start) begin
        pc   <= '0;
        done <= 1'b0;
      end
      if (state == S_DECODE) begin
        ir <= imem_data;
        pc <= pc + WIDTH'(1);
      end
      if (state == S_OPERAND) begin
        opr <= imem_data;
        pc  <= pc + WIDTH'(1);
      end
      if (state == S_EXEC && !stall) begin
        if (dec.writes_ac) AC <= cls == CLS_LDB ? BusOut : cls == CLS_ALU ? result_ac : opr;
        if (dec.is_jump && (cls == CLS_JMP || AC == '0)) pc <= opr;
        if (dec.is_halt) done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_core_control_unit.sv
// tb_core_control_unit: directed program runs against a behavioural ROM and adder ALU
module tb_core_control_unit;
  logic       Clk, Reset, start, bus_valid, bus_req, done;
  logic [7:0] core_id_in, imem_addr, imem_data, BusOut, result_ac, AC, coreID;
  logic [3:0] ALU_OP;
  logic [7:0] rom [256];
  int         errors = 0;
  int         checks = 0;
  core_control_unit #(.WIDTH(8), .CORE_ID_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .core_id_in(core_id_in),
    .imem_addr(imem_addr), .imem_data(imem_data), .BusOut(BusOut),
    .bus_valid(bus_valid), .bus_req(bus_req), .result_ac(result_ac),
    .AC(AC), .ALU_OP(ALU_OP), .coreID(coreID), .done(done)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) imem_data <= rom[imem_addr];
  assign result_ac = ALU_OP == 4'h1 ? AC + BusOut : AC;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic run_until_done(input string tag);
    for (int i = 0; i < 50 && !done; i++) tick();
    chk(tag, {31'b0, done}, 32'h1);
  endtask
  initial begin
    Reset = 1'b1; start = 1'b0; core_id_in = 8'h03; bus_valid = 1'b0; BusOut = 8'h00;
    clear_rom();
    rom[0] = 8'h30; rom[1] = 8'h15; rom[2] = 8'hF0;
    tick();
    chk("rst_ac", {24'b0, AC}, 32'h0);
    chk("rst_coreid", {24'b0, coreID}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_addr", {24'b0, imem_addr}, 32'h0);
    chk("rst_busreq", {31'b0, bus_req}, 32'h0);
    chk("rst_aluop", {28'b0, ALU_OP}, 32'h0);
    Reset = 1'b0;
    tick();
    chk("coreid", {24'b0, coreID}, 32'h03);
    // LDI 15 then HALT
    pulse_start();
    repeat (3) tick();
    chk("ldi_early", {24'b0, AC}, 32'h0);
    tick();
    chk("ldi_ac", {24'b0, AC}, 32'h15);
    chk("ldi_done_lo", {31'b0, done}, 32'h0);
    repeat (2) tick();
    chk("halt_early", {31'b0, done}, 32'h0);
    tick();
    chk("halt_done", {31'b0, done}, 32'h1);
    chk("halt_pc", {24'b0, imem_addr}, 32'h03);
    repeat (2) tick();
    chk("idle_ac", {24'b0, AC}, 32'h15);
    chk("idle_done", {31'b0, done}, 32'h1);
    // restart, then reset while LDB stalls
    rom[2] = 8'h10;
    pulse_start();
    chk("restart_done", {31'b0, done}, 32'h0);
    repeat (6) tick();
    chk("stall_busreq", {31'b0, bus_req}, 32'h1);
    tick();
    chk("stall_ac", {24'b0, AC}, 32'h15);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_ac", {24'b0, AC}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_busreq", {31'b0, bus_req}, 32'h0);
    chk("midrst_addr", {24'b0, imem_addr}, 32'h0);
    tick();
    Reset = 1'b0;
    // LDB, ALU ADD with delayed bus, HALT; start pulsed during the stall
    rom[0] = 8'h10; rom[1] = 8'h21; rom[2] = 8'hF0;
    BusOut = 8'h11; bus_valid = 1'b1;
    pulse_start();
    repeat (2) tick();
    chk("ldb_busreq", {31'b0, bus_req}, 32'h1);
    chk("ldb_aluop", {28'b0, ALU_OP}, 32'h0);
    tick();
    chk("ldb_ac", {24'b0, AC}, 32'h11);
    bus_valid = 1'b0; BusOut = 8'hAA;
    repeat (2) tick();
    chk("alu_aluop", {28'b0, ALU_OP}, 32'h1);
    chk("alu_busreq", {31'b0, bus_req}, 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_aluop", {28'b0, ALU_OP}, 32'h1);
    chk("ign_start_busreq", {31'b0, bus_req}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("alu_hold_ac", {24'b0, AC}, 32'h11);
      tick();
    end
    chk("alu_hold_ac", {24'b0, AC}, 32'h11);
    chk("alu_hold_op", {28'b0, ALU_OP}, 32'h1);
    bus_valid = 1'b1;
    tick();
    bus_valid = 1'b0;
    chk("alu_ac", {24'b0, AC}, 32'hBB);
    chk("alu_op_off", {28'b0, ALU_OP}, 32'h0);
    chk("alu_busreq_off", {31'b0, bus_req}, 32'h0);
    repeat (3) tick();
    chk("alu_halt", {31'b0, done}, 32'h1);
    // JZ taken and not taken
    clear_rom();
    rom[0] = 8'h30; rom[1] = 8'h00; rom[2] = 8'h50; rom[3] = 8'h10;
    rom[4] = 8'hF0; rom[16] = 8'hF0;
    pulse_start();
    run_until_done("jz_taken_done");
    chk("jz_taken_pc", {24'b0, imem_addr}, 32'h11);
    chk("jz_taken_ac", {24'b0, AC}, 32'h0);
    rom[1] = 8'h01;
    pulse_start();
    run_until_done("jz_fall_done");
    chk("jz_fall_pc", {24'b0, imem_addr}, 32'h05);
    chk("jz_fall_ac", {24'b0, AC}, 32'h01);
    // JMP FE, NOPs at FE/FF, PC wraps to 0
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'hFE;
    pulse_start();
    repeat (4) tick();
    chk("jmp_target", {24'b0, imem_addr}, 32'hFE);
    repeat (3) tick();
    chk("wrap_ff", {24'b0, imem_addr}, 32'hFF);
    repeat (3) tick();
    chk("wrap_00", {24'b0, imem_addr}, 32'h00);
    tick();
    chk("wrap_operand", {24'b0, imem_addr}, 32'h01);
    chk("wrap_done", {31'b0, done}, 32'h0);
    Reset = 1'b1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
